// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Definitions shared by the PC / instruction-fetch slice of the MIPS core:
//     - fetch_state_e : fetch FSM states (BOOT, FETCH, EXEC)
//     - npc_sel_e     : next-PC source select (sequential, branch, jump, jr)
//     - RESET_PC_DEFAULT : default PC loaded on reset (word aligned)
//     - word_align()  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
//   Purely combinational next-PC selection.
//   Ports:
//     pc          in  32  current PC
//     branch_en   in  1   take conditional branch
//     branch_off  in  16  signed branch immediate, in words
//     jump_en     in  1   take j/jal
//     jump_addr   in  32  j/jal target, already shifted and concatenated
//     jr_en       in  1   take jr/jalr
//     jr_addr     in  32  register target
//     pc_plus4    out 32  pc + 4 (wraps modulo 2^32)
//     next_pc     out 32  selected next PC (jr > jump > branch > sequential)
//     jr_misalign out 1   jr selected and its target has nonzero [1:0]
// -----------------------------------------------------------------------------
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_en,
  input  logic [15:0] branch_off,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        jr_misalign
);

  npc_sel_e    sel;
  logic [31:0] branch_target;

  assign pc_plus4 = pc + 32'd4;

  // Word offset sign-extended and scaled to bytes; the add wraps naturally.
  assign branch_target = pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00};

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    sel = NPC_SEQ;
    if (jr_en)          sel = NPC_JR;
    else if (jump_en)   sel = NPC_J;
    else if (branch_en) sel = NPC_BR;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      NPC_JR:  next_pc = word_align(jr_addr);
      NPC_J:   next_pc = jump_addr;
      NPC_BR:  next_pc = branch_target;
      default: next_pc = pc_plus4;
    endcase
  end

  assign jr_misalign = (sel == NPC_JR) && (jr_addr[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program counter and instruction fetch stage. Fetches one word per
//   instruction over a req/ready handshake, holds it for decode until it is
//   released (instr_valid & !stall), then redirects to the selected next PC.
//   Parameter:
//     RESET_PC    PC loaded on reset (low two bits are forced to zero)
//   Ports:
//     clk, rst    clock; synchronous active-high reset
//     stall       decode/execute not ready, hold the current instruction
//     branch_en/branch_off, jump_en/jump_addr, jr_en/jr_addr
//                 redirect requests, sampled only on advance
//     imem_req    fetch request (registered)
//     imem_addr   fetch address (= pc, registered)
//     imem_ready  memory returns imem_rdata this cycle (FETCH only)
//     imem_rdata  fetched word
//     instr_valid instr/pc_out valid for decode
//     instr       current instruction
//     pc_out      address of instr
//     pc_plus4    pc_out + 4
//     pc4_hi      pc_plus4[31:28] for the jump-address shifter
//     misalign    one-cycle pulse after advancing on a misaligned jr target
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [15:0] branch_off,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [3:0]  pc4_hi,
  output logic        misalign
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         jr_misalign;
  logic         advance;

  next_pc_sel u_next_pc_sel (
    .pc          (pc),
    .branch_en   (branch_en),
    .branch_off  (branch_off),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .jr_en       (jr_en),
    .jr_addr     (jr_addr),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc),
    .jr_misalign (jr_misalign)
  );

  // Redirect controls matter only on the cycle decode releases the instruction.
  assign advance = (state == EXEC) && instr_valid && !stall;

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign pc4_hi    = pc_plus4[31:28];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // misalign is a single-cycle pulse; only the advance branch raises it.
    misalign <= 1'b0;
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC_ALIGNED;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            state       <= EXEC;
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
          end
        end
        EXEC: begin
          if (advance) begin
            // Request goes straight to the target: no wrong-path fetch.
            state       <= FETCH;
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            misalign    <= jr_misalign;
          end
        end
        default: begin
          state       <= BOOT;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule
